matrix_gen_scheduler: RTL and testbench

Sequencer and two-way arbiter in front of the random matrix generator. Accepts matrix-fill requests from two requesters (manual input path and auto-operand path), normalises their parameters, drives the generator's level-sensitive update handshake, and emits a store strobe so the fill lands in the requested matrix-storage slot. Sits between the top-level mode FSM and the generator/storage pair.

---
 rtl/matrix_gen_scheduler_pkg.sv | 44 ++++
 rtl/matrix_gen_scheduler_if.sv | 50 +++++
 rtl/matrix_gen_scheduler_arb.sv | 34 +++
 rtl/matrix_gen_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_matrix_gen_scheduler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_gen_scheduler_pkg.sv
// matrix_gen_pkg: shared types and helpers for matrix_gen_scheduler.
//   mg_state_e  - scheduler FSM state encoding
//   MG_MAX_DIM  - largest row/column count the generator accepts
//   MG_TIMEOUT  - default WAIT_DONE abort limit in cycles
//   clamp_dim   - maps a raw 3-bit dimension into 1..max_d
//   order_bounds - returns {lo, hi} of two unsigned bytes
package matrix_gen_pkg;

  localparam int MG_MAX_DIM = 5;
  localparam int MG_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_STORE     = 3'd4,
    ST_RELEASE   = 3'd5
  } mg_state_e;

  // A zero dimension is promoted to 1 so the generator never sees an
  // empty matrix; oversize requests are clipped to max_d.
  function automatic logic [2:0] clamp_dim(input logic [2:0] d,
                                           input logic [2:0] max_d);
    if (d == 3'd0) begin
      return 3'd1;
    end else if (d > max_d) begin
      return max_d;
    end else begin
      return d;
    end
  endfunction

  // Unsigned ordering of an 8-bit bound pair: result is {lo, hi}.
  function automatic logic [15:0] order_bounds(input logic [7:0] a,
                                               input logic [7:0] b);
    if (a > b) begin
      return {b, a};
    end else begin
      return {a, b};
    end
  endfunction

endpackage

// File: rtl/matrix_gen_scheduler_if.sv
// matrix_gen_scheduler_if: bundles the two-requester request bus, the
// generator handshake and the storage capture port.
//   slave  - scheduler view (consumes requests, drives generator/storage)
//   master - environment view (requesters, generator, storage)
// Parameters: WIDTH (element width), SLOT_W (storage slot index width).
interface matrix_gen_scheduler_if #(
  parameter int WIDTH  = 8,
  parameter int SLOT_W = 2
);
  logic [1:0]          req_valid;
  logic [5:0]          req_row;
  logic [5:0]          req_col;
  logic [2*WIDTH-1:0]  req_min;
  logic [2*WIDTH-1:0]  req_max;
  logic [2*SLOT_W-1:0] req_slot;
  logic [1:0]          req_done;
  logic [1:0]          req_err;

  logic [2:0]          gen_row;
  logic [2:0]          gen_col;
  logic [WIDTH-1:0]    gen_min;
  logic [WIDTH-1:0]    gen_max;
  logic                gen_update_en;
  logic                gen_update_done;

  logic                store_we;
  logic [SLOT_W-1:0]   store_slot;
  logic [2:0]          store_row;
  logic [2:0]          store_col;

  logic                busy;

  modport slave (
    input  req_valid, req_row, req_col, req_min, req_max, req_slot,
    input  gen_update_done,
    output req_done, req_err,
    output gen_row, gen_col, gen_min, gen_max, gen_update_en,
    output store_we, store_slot, store_row, store_col,
    output busy
  );

  modport master (
    output req_valid, req_row, req_col, req_min, req_max, req_slot,
    output gen_update_done,
    input  req_done, req_err,
    input  gen_row, gen_col, gen_min, gen_max, gen_update_en,
    input  store_we, store_slot, store_row, store_col,
    input  busy
  );
endinterface

// File: rtl/matrix_gen_scheduler_arb.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   clk, rst_n  - clock, synchronous active-low reset
//   req_i       - request vector
//   accept_i    - the current grant was taken this cycle
//   gnt_vld_o   - some request is pending
//   gnt_idx_o   - index of the winning requester
// The pointer names the preferred requester; after an accepted grant it
// moves to the requester that lost, so a lone requester always wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d     = accept_i ? ~gnt_idx_o : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/matrix_gen_scheduler.sv
// matrix_gen_scheduler: arbitrates matrix-fill requests from two
// requesters, normalises dims/bounds, drives the generator's level
// update handshake and strobes the result into a storage slot.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - matrix_gen_scheduler_if.slave (requests, generator, storage, busy)
// Build option: MATRIX_GEN_TIMEOUT_EN enables the WAIT_DONE abort counter
// and req_err; without it WAIT_DONE waits indefinitely and req_err is 0.
//
// state      | meaning
// IDLE       | waiting for a request; gen_* hold the last fill
// LAUNCH     | first cycle of gen_update_en; stale done diverts to RELEASE
// WAIT_DONE  | gen_update_en held until gen_update_done
// SETTLE     | one cycle for generator outputs to settle
// STORE      | store_we and req_done to the granted requester
// RELEASE    | gen_update_en low until done clears; relaunch if stale
module matrix_gen_scheduler
  import matrix_gen_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_DIM = MG_MAX_DIM,
  parameter int SLOT_W  = 2,
  parameter int TIMEOUT = MG_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst_n,
  matrix_gen_scheduler_if.slave  bus
);

  mg_state_e         state_q, state_d;
  logic              grant_q, grant_d;
  logic              relaunch_q, relaunch_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [WIDTH-1:0]  min_q, min_d, max_q, max_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic              gnt_vld, gnt_idx, grant_accept;
  logic              gen_en, store_pulse;
  logic [1:0]        grant_vec;
  logic [2:0]        sel_row, sel_col;
  logic [WIDTH-1:0]  sel_min, sel_max;
  logic [SLOT_W-1:0] sel_slot;

`ifdef MATRIX_GEN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_pulse;
`endif

  assign grant_accept = (state_q == ST_IDLE) && gnt_vld;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid),
    .accept_i  (grant_accept),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_row  = gnt_idx ? bus.req_row[5:3]             : bus.req_row[2:0];
    sel_col  = gnt_idx ? bus.req_col[5:3]             : bus.req_col[2:0];
    sel_min  = gnt_idx ? bus.req_min[2*WIDTH-1:WIDTH] : bus.req_min[WIDTH-1:0];
    sel_max  = gnt_idx ? bus.req_max[2*WIDTH-1:WIDTH] : bus.req_max[WIDTH-1:0];
    sel_slot = gnt_idx ? bus.req_slot[2*SLOT_W-1:SLOT_W] : bus.req_slot[SLOT_W-1:0];
  end

  // Parameters are captured only at grant, so requesters may change req_*
  // freely while their fill is in flight.
  always_comb begin
    grant_d = grant_q;
    row_d   = row_q;
    col_d   = col_q;
    min_d   = min_q;
    max_d   = max_q;
    slot_d  = slot_q;
    if (grant_accept) begin
      grant_d = gnt_idx;
      row_d   = clamp_dim(sel_row, 3'(MAX_DIM));
      col_d   = clamp_dim(sel_col, 3'(MAX_DIM));
      slot_d  = sel_slot;
      if (sel_min > sel_max) begin
        min_d = sel_max;
        max_d = sel_min;
      end else begin
        min_d = sel_min;
        max_d = sel_max;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    relaunch_d  = relaunch_q;
    gen_en      = 1'b0;
    store_pulse = 1'b0;
`ifdef MATRIX_GEN_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_pulse   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_d    = ST_LAUNCH;
          relaunch_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        gen_en = 1'b1;
        // Done already high here cannot belong to this launch.
        if (bus.gen_update_done) begin
          state_d    = ST_RELEASE;
          relaunch_d = 1'b1;
        end else begin
          state_d = ST_WAIT_DONE;
`ifdef MATRIX_GEN_TIMEOUT_EN
          cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
        end
      end
      ST_WAIT_DONE: begin
        gen_en = 1'b1;
        if (bus.gen_update_done) begin
          state_d = ST_SETTLE;
        end
`ifdef MATRIX_GEN_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_pulse = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      ST_SETTLE: begin
        gen_en  = 1'b1;
        state_d = ST_STORE;
      end
      ST_STORE: begin
        store_pulse = 1'b1;
        state_d     = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.gen_update_done) begin
          state_d    = relaunch_q ? ST_LAUNCH : ST_IDLE;
          relaunch_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        relaunch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      relaunch_q <= 1'b0;
      row_q      <= 3'd1;
      col_q      <= 3'd1;
      min_q      <= '0;
      max_q      <= '0;
      slot_q     <= '0;
`ifdef MATRIX_GEN_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      relaunch_q <= relaunch_d;
      row_q      <= row_d;
      col_q      <= col_d;
      min_q      <= min_d;
      max_q      <= max_d;
      slot_q     <= slot_d;
`ifdef MATRIX_GEN_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign grant_vec         = grant_q ? 2'b10 : 2'b01;
  assign bus.gen_row       = row_q;
  assign bus.gen_col       = col_q;
  assign bus.gen_min       = min_q;
  assign bus.gen_max       = max_q;
  assign bus.gen_update_en = gen_en;
  assign bus.store_we      = store_pulse;
  assign bus.store_slot    = store_pulse ? slot_q : '0;
  assign bus.store_row     = store_pulse ? row_q  : '0;
  assign bus.store_col     = store_pulse ? col_q  : '0;
  assign bus.req_done      = store_pulse ? grant_vec : 2'b00;
  assign bus.busy          = (state_q != ST_IDLE);
`ifdef MATRIX_GEN_TIMEOUT_EN
  assign bus.req_err       = err_pulse ? grant_vec : 2'b00;
`else
  assign bus.req_err       = 2'b00;
`endif

endmodule

// File: tb/tb_matrix_gen_scheduler.sv
module tb_matrix_gen_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_gen_scheduler_if #(.WIDTH(8), .SLOT_W(2)) gif ();

  matrix_gen_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif.slave)
  );

  typedef struct {
    logic [1:0] slot;
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [1:0] mask;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rise_cyc = -100;
  int   en_cnt = 0;
  bit   withhold = 1'b0;
  bit   stale_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Generator model: done rises on the third cycle of a held enable,
  // drops once the enable is removed. stale_hold forces done high.
  always @(negedge clk) begin
    logic done_n;
    if (stale_hold) begin
      done_n = 1'b1;
    end else if (gif.gen_update_en === 1'b1) begin
      en_cnt++;
      done_n = !withhold && (en_cnt >= 3);
    end else begin
      en_cnt = 0;
      done_n = 1'b0;
    end
    if (done_n && !gif.gen_update_done) rise_cyc = cyc;
    gif.gen_update_done = done_n;
  end

  // Storage-side scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("done_with_store", 32'(|gif.req_done), 32'(gif.store_we));
    if (gif.store_we === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("store_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("store_slot",    32'(gif.store_slot), 32'(e.slot));
        chk("store_row",     32'(gif.store_row),  32'(e.row));
        chk("store_col",     32'(gif.store_col),  32'(e.col));
        chk("gen_row",       32'(gif.gen_row),    32'(e.row));
        chk("gen_col",       32'(gif.gen_col),    32'(e.col));
        chk("gen_min",       32'(gif.gen_min),    32'(e.mn));
        chk("gen_max",       32'(gif.gen_max),    32'(e.mx));
        chk("req_done_mask", 32'(gif.req_done),   32'(e.mask));
        chk("store_latency", 32'(cyc),            32'(rise_cyc + 2));
      end
    end
  end

  task automatic req_load(input int idx, input logic [2:0] r, input logic [2:0] c,
                          input logic [7:0] mn, input logic [7:0] mx,
                          input logic [1:0] s, input bit push);
    exp_t e;
    gif.req_row[idx*3 +: 3] = r;
    gif.req_col[idx*3 +: 3] = c;
    gif.req_min[idx*8 +: 8] = mn;
    gif.req_max[idx*8 +: 8] = mx;
    gif.req_slot[idx*2 +: 2] = s;
    e.slot = s;
    e.row  = (r == 3'd0) ? 3'd1 : ((r > 3'd5) ? 3'd5 : r);
    e.col  = (c == 3'd0) ? 3'd1 : ((c > 3'd5) ? 3'd5 : c);
    e.mn   = (mn > mx) ? mx : mn;
    e.mx   = (mn > mx) ? mn : mx;
    e.mask = (idx == 1) ? 2'b10 : 2'b01;
    if (push) sbq.push_back(e);
  endtask

  task automatic wait_done(input int idx, input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (gif.req_done[idx] === 1'b1) break;
    end
    chk(tag, 32'(k < 300), 32'd1);
    gif.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (gif.busy === 1'b0) break;
    end
    chk(tag, 32'(gif.busy), 32'd0);
  endtask

  initial begin
    gif.req_valid = '0;
    gif.req_row = '0;
    gif.req_col = '0;
    gif.req_min = '0;
    gif.req_max = '0;
    gif.req_slot = '0;
    gif.gen_update_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(gif.busy),          32'd0);
    chk("rst_gen_row",  32'(gif.gen_row),       32'd1);
    chk("rst_gen_col",  32'(gif.gen_col),       32'd1);
    chk("rst_gen_min",  32'(gif.gen_min),       32'd0);
    chk("rst_gen_max",  32'(gif.gen_max),       32'd0);
    chk("rst_gen_en",   32'(gif.gen_update_en), 32'd0);
    chk("rst_store_we", 32'(gif.store_we),      32'd0);
    chk("rst_req_done", 32'(gif.req_done),      32'd0);
    chk("rst_req_err",  32'(gif.req_err),       32'd0);
    rst_n = 1'b1;

    // Basic fill from requester 0.
    req_load(0, 3'd3, 3'd4, 8'd10, 8'd50, 2'd2, 1'b1);
    gif.req_valid = 2'b01;
    @(posedge clk); #1;
    chk("launch_en",   32'(gif.gen_update_en), 32'd1);
    chk("launch_busy", 32'(gif.busy),          32'd1);
    wait_done(0, "t1_done");
    wait_idle("t1_idle");
    chk("hold_gen_row", 32'(gif.gen_row), 32'd3);
    chk("hold_gen_col", 32'(gif.gen_col), 32'd4);

    // Normalisation: zero/oversize dims, swapped and equal bounds.
    req_load(0, 3'd0, 3'd7, 8'd90, 8'd20, 2'd1, 1'b1);
    gif.req_valid = 2'b01;
    wait_done(0, "norm_done");
    wait_idle("norm_idle");
    chk("norm_hold_min", 32'(gif.gen_min), 32'd20);
    chk("norm_hold_max", 32'(gif.gen_max), 32'd90);
    req_load(1, 3'd5, 3'd6, 8'd33, 8'd33, 2'd3, 1'b1);
    gif.req_valid = 2'b10;
    wait_done(1, "eq_done");
    wait_idle("eq_idle");

    // Round robin from a fresh pointer.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_load(0, 3'd2, 3'd2, 8'd1, 8'd2, 2'd0, 1'b1);
    req_load(1, 3'd4, 3'd1, 8'd5, 8'd6, 2'd3, 1'b1);
    gif.req_valid = 2'b11;
    wait_done(0, "rr_a0");
    wait_done(1, "rr_a1");
    wait_idle("rr_a_idle");
    req_load(0, 3'd1, 3'd3, 8'd7, 8'd8, 2'd1, 1'b1);
    req_load(1, 3'd3, 3'd3, 8'd9, 8'd9, 2'd2, 1'b1);
    gif.req_valid = 2'b11;
    wait_done(0, "rr_b0");
    wait_done(1, "rr_b1");
    wait_idle("rr_b_idle");

    // Stale done at launch: release first, then one real fill.
    stale_hold = 1'b1;
    req_load(0, 3'd2, 3'd3, 8'd4, 8'd5, 2'd2, 1'b1);
    gif.req_valid = 2'b01;
    repeat (4) begin @(posedge clk); #1; end
    chk("stale_en_low", 32'(gif.gen_update_en), 32'd0);
    chk("stale_busy",   32'(gif.busy),          32'd1);
    stale_hold = 1'b0;
    wait_done(0, "stale_done");
    wait_idle("stale_idle");

    // Reset during WAIT_DONE; held request is served afterwards.
    withhold = 1'b1;
    req_load(1, 3'd4, 3'd4, 8'd11, 8'd22, 2'd1, 1'b1);
    gif.req_valid = 2'b10;
    repeat (5) begin @(posedge clk); #1; end
    chk("wait_en", 32'(gif.gen_update_en), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy",  32'(gif.busy),          32'd0);
    chk("mid_rst_en",    32'(gif.gen_update_en), 32'd0);
    chk("mid_rst_store", 32'(gif.store_we),      32'd0);
    chk("mid_rst_done",  32'(gif.req_done),      32'd0);
    rst_n = 1'b1;
    withhold = 1'b0;
    wait_done(1, "rerequest_done");
    wait_idle("rerequest_idle");

    // Generator withholds done.
    withhold = 1'b1;
`ifdef MATRIX_GEN_TIMEOUT_EN
    begin
      int k;
      req_load(1, 3'd2, 3'd2, 8'd3, 8'd4, 2'd0, 1'b0);
      gif.req_valid = 2'b10;
      for (k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (gif.gen_update_en === 1'b1) break;
      end
      chk("to_en_rise", 32'(gif.gen_update_en), 32'd1);
      for (k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (gif.req_err !== 2'b00) break;
        k = k;
      end
      chk("to_cycles",   32'(k + 1),         32'd64);
      chk("to_err_mask", 32'(gif.req_err),   32'd2);
      chk("to_no_store", 32'(gif.store_we),  32'd0);
      gif.req_valid = 2'b00;
      @(posedge clk); #1;
      chk("to_en_drop",  32'(gif.gen_update_en), 32'd0);
      chk("to_err_once", 32'(gif.req_err),       32'd0);
      withhold = 1'b0;
      wait_idle("to_idle");
    end
`else
    req_load(1, 3'd2, 3'd2, 8'd3, 8'd4, 2'd0, 1'b1);
    gif.req_valid = 2'b10;
    repeat (100) begin @(posedge clk); #1; end
    chk("long_wait_en",   32'(gif.gen_update_en), 32'd1);
    chk("long_wait_err",  32'(gif.req_err),       32'd0);
    chk("long_wait_busy", 32'(gif.busy),          32'd1);
    withhold = 1'b0;
    wait_done(1, "long_wait_done");
    wait_idle("long_wait_idle");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
